// File: rtl/telem_pkg.sv
// rtl/telem_pkg.sv - shared encodings for the telemetry bank write sequencer
package telem_pkg;

    localparam int NSLOT = 32;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_LOAD  = 2'b01;
    localparam logic [1:0] SEL_CLEAR = 2'b11;

    localparam logic [1:0] FLD_X    = 2'd0;
    localparam logic [1:0] FLD_Y    = 2'd1;
    localparam logic [1:0] FLD_Z    = 2'd2;
    localparam logic [1:0] FLD_TIME = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/telem_rr_arbiter.sv
// rtl/telem_rr_arbiter.sv - combinational round-robin arbiter starting at rr_ptr
module telem_rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   rr_ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx
);

    int idx;

    // Walk from lowest to highest priority so the highest-priority hit wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (enable && valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/telem_write_sequencer.sv
// rtl/telem_write_sequencer.sv - arbitrates telemetry records and sequences bank loads and clear sweeps
module telem_write_sequencer
    import telem_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*5-1:0]   req_slot,
    input  logic [NREQ*4*W-1:0] req_data,
    input  logic                clr_all,
    output logic                bank_en,
    output logic [4:0]          bank_addr,
    output logic [1:0]          bank_field,
    output logic [1:0]          bank_sel,
    output logic [W-1:0]        bank_data,
    output logic                busy,
    output logic                done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic            clr_pend;
    logic [4:0]      cnt;
    logic [4*W-1:0]  rec;

    logic            grant_en;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;

    // Requests are only offered when no clear is waiting; reset also masks the grant.
    assign grant_en  = (state == ST_IDLE) && !clr_pend && !clr_all && !rst;
    assign req_ready = grant;

    telem_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr),
        .enable    (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            clr_pend   <= 1'b0;
            cnt        <= '0;
            rec        <= '0;
            bank_en    <= 1'b0;
            bank_addr  <= '0;
            bank_field <= FLD_X;
            bank_sel   <= SEL_HOLD;
            bank_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clr_pend || clr_all) begin
                        // clr_pend stays set through the sweep so further clr_all pulses merge.
                        state      <= ST_CLEAR;
                        clr_pend   <= 1'b1;
                        cnt        <= '0;
                        bank_en    <= 1'b1;
                        busy       <= 1'b1;
                        bank_addr  <= '0;
                        bank_field <= FLD_X;
                        bank_sel   <= SEL_CLEAR;
                        bank_data  <= '0;
                    end else if (|grant) begin
                        state      <= ST_WRITE;
                        cnt        <= '0;
                        rec        <= req_data[int'(grant_idx)*4*W +: 4*W];
                        rr_ptr     <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
                        bank_en    <= 1'b1;
                        busy       <= 1'b1;
                        bank_addr  <= req_slot[int'(grant_idx)*5 +: 5];
                        bank_field <= FLD_X;
                        bank_sel   <= SEL_LOAD;
                        bank_data  <= req_data[int'(grant_idx)*4*W +: W];
                    end
                end
                ST_WRITE: begin
                    if (clr_all) begin
                        clr_pend <= 1'b1;
                    end
                    if (cnt[1:0] == FLD_TIME) begin
                        state      <= ST_IDLE;
                        done       <= 1'b1;
                        cnt        <= '0;
                        bank_en    <= 1'b0;
                        busy       <= 1'b0;
                        bank_addr  <= '0;
                        bank_field <= FLD_X;
                        bank_sel   <= SEL_HOLD;
                        bank_data  <= '0;
                    end else begin
                        cnt        <= cnt + 5'd1;
                        bank_field <= cnt[1:0] + 2'd1;
                        bank_data  <= rec[int'(cnt[1:0] + 2'd1)*W +: W];
                    end
                end
                ST_CLEAR: begin
                    if (cnt == 5'(NSLOT - 1)) begin
                        state      <= ST_IDLE;
                        done       <= 1'b1;
                        clr_pend   <= 1'b0;
                        cnt        <= '0;
                        bank_en    <= 1'b0;
                        busy       <= 1'b0;
                        bank_addr  <= '0;
                        bank_field <= FLD_X;
                        bank_sel   <= SEL_HOLD;
                        bank_data  <= '0;
                    end else begin
                        cnt       <= cnt + 5'd1;
                        bank_addr <= cnt + 5'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_telem_write_sequencer.sv
// tb/tb_telem_write_sequencer.sv - table, directed and random checks against a schedule-queue model
module tb_telem_write_sequencer;

    localparam int NREQ = 3;
    localparam int W    = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*5-1:0]   req_slot;
    logic [NREQ*4*W-1:0] req_data;
    logic                clr_all;
    logic                bank_en;
    logic [4:0]          bank_addr;
    logic [1:0]          bank_field;
    logic [1:0]          bank_sel;
    logic [W-1:0]        bank_data;
    logic                busy;
    logic                done;

    logic [4:0]  sl [NREQ];
    logic [31:0] dt [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_slot[i*5 +: 5]   = sl[i];
            req_data[i*32 +: 32] = dt[i];
        end
    end

    telem_write_sequencer #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_slot   (req_slot),
        .req_data   (req_data),
        .clr_all    (clr_all),
        .bank_en    (bank_en),
        .bank_addr  (bank_addr),
        .bank_field (bank_field),
        .bank_sel   (bank_sel),
        .bank_data  (bank_data),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic       en;
        logic [4:0] addr;
        logic [1:0] field;
        logic [1:0] sel;
        logic [7:0] data;
        logic       done;
    } op_t;

    typedef struct {
        logic       rst;
        logic [2:0] valid;
        logic       clr;
        logic [2:0] ready;
        op_t        o;
    } vec_t;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int n_clear, n_done;
    logic [22:0] last_act;

    // Model: queue of per-cycle expected bank activity; empty or a done entry means idle.
    op_t q[$];
    int  rr = 0;
    bit  pend = 0;
    bit  sweeping = 0;

    function automatic op_t mkop(logic en, logic [4:0] addr, logic [1:0] field,
                                 logic [1:0] sel, logic [7:0] data, logic dn);
        op_t o;
        o.en = en; o.addr = addr; o.field = field; o.sel = sel; o.data = data; o.done = dn;
        return o;
    endfunction

    function automatic logic [22:0] pack(logic [2:0] ready, op_t o);
        return {ready, o.en, o.addr, o.field, o.sel, o.data, o.en, o.done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit use_tbl, input logic [22:0] tbl_exp);
        op_t        op;
        logic [2:0] exp_ready;
        bit         found;
        int         w;
        @(negedge clk);
        last_act = {req_ready, bank_en, bank_addr, bank_field, bank_sel, bank_data, busy, done};
        if (bank_en && bank_sel == 2'b11) n_clear++;
        if (done) n_done++;
        op = (q.size() > 0) ? q.pop_front() : mkop(0, 0, 0, 0, 0, 0);
        exp_ready = 3'b000;
        if (rst) begin
            q.delete();
            rr = 0; pend = 0; sweeping = 0;
        end else if (!op.en) begin
            if (pend || clr_all) begin
                for (int a = 0; a < 32; a++) q.push_back(mkop(1, 5'(a), 2'd0, 2'b11, 8'd0, 0));
                q.push_back(mkop(0, 0, 0, 0, 0, 1));
                pend = 0; sweeping = 1;
            end else if (|req_valid) begin
                found = 0; w = 0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req_valid[(rr + k) % NREQ]) begin
                        found = 1; w = (rr + k) % NREQ;
                    end
                end
                exp_ready[w] = 1'b1;
                for (int f = 0; f < 4; f++) q.push_back(mkop(1, sl[w], 2'(f), 2'b01, dt[w][f*8 +: 8], 0));
                q.push_back(mkop(0, 0, 0, 0, 0, 1));
                rr = (w + 1) % NREQ; sweeping = 0;
            end
        end else if (clr_all && !sweeping) begin
            pend = 1;
        end
        check("model", 32'(last_act), 32'(pack(exp_ready, op)));
        if (use_tbl) check("table", 32'(last_act), 32'(tbl_exp));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    vec_t tbl[$];

    task automatic add(logic r, logic [2:0] v, logic c, logic [2:0] rdy, logic en,
                       logic [4:0] addr, logic [1:0] fld, logic [1:0] sel, logic [7:0] d, logic dn);
        vec_t t;
        t.rst = r; t.valid = v; t.clr = c; t.ready = rdy;
        t.o = mkop(en, addr, fld, sel, d, dn);
        tbl.push_back(t);
    endtask

    logic [2:0] grants[$];
    logic [2:0] exp_g [4];

    initial begin
        rst = 1'b1; req_valid = '0; clr_all = 1'b0;
        sl[0] = 5'd3;  dt[0] = 32'hA4A3A2A1;
        sl[1] = 5'd7;  dt[1] = 32'h40302010;
        sl[2] = 5'd20; dt[2] = 32'hC4C3C2C1;
        @(posedge clk);
        #1;

        // reset with all requesting, first grant to 0, then a single write from requester 1
        add(1, 3'b111, 0, 3'b000, 0, 0, 0, 2'b00, 8'h00, 0);
        add(1, 3'b111, 0, 3'b000, 0, 0, 0, 2'b00, 8'h00, 0);
        add(0, 3'b111, 0, 3'b001, 0, 0, 0, 2'b00, 8'h00, 0);
        add(0, 3'b000, 0, 3'b000, 1, 3, 0, 2'b01, 8'hA1, 0);
        add(0, 3'b000, 0, 3'b000, 1, 3, 1, 2'b01, 8'hA2, 0);
        add(0, 3'b000, 0, 3'b000, 1, 3, 2, 2'b01, 8'hA3, 0);
        add(0, 3'b000, 0, 3'b000, 1, 3, 3, 2'b01, 8'hA4, 0);
        add(0, 3'b010, 0, 3'b010, 0, 0, 0, 2'b00, 8'h00, 1);
        add(0, 3'b000, 0, 3'b000, 1, 7, 0, 2'b01, 8'h10, 0);
        add(0, 3'b000, 0, 3'b000, 1, 7, 1, 2'b01, 8'h20, 0);
        add(0, 3'b000, 0, 3'b000, 1, 7, 2, 2'b01, 8'h30, 0);
        add(0, 3'b000, 0, 3'b000, 1, 7, 3, 2'b01, 8'h40, 0);
        add(0, 3'b000, 0, 3'b000, 0, 0, 0, 2'b00, 8'h00, 1);
        add(0, 3'b000, 0, 3'b000, 0, 0, 0, 2'b00, 8'h00, 0);
        foreach (tbl[i]) begin
            rst = tbl[i].rst; req_valid = tbl[i].valid; clr_all = tbl[i].clr;
            step(1, pack(tbl[i].ready, tbl[i].o));
        end

        // round-robin with all three requesting continuously after a reset
        rst = 1'b1; req_valid = 3'b111;
        step(0, '0); step(0, '0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(0, '0);
            if (last_act[22:20] != 3'b000) grants.push_back(last_act[22:20]);
        end
        req_valid = '0;
        for (int i = 0; i < 6; i++) step(0, '0);
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        check("rr_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) check("rr_grant", 32'(grants[i]), 32'(exp_g[i]));

        // clear together with a request: sweep wins, requester 2 granted on the done cycle
        n_clear = 0;
        for (int i = 0; i <= 33; i++) begin
            clr_all = (i == 0); req_valid = 3'b100;
            step(0, '0);
            if (i == 33) check("clr_done_grant", 32'({last_act[22:20], last_act[0]}), 32'({3'b100, 1'b1}));
        end
        clr_all = 1'b0; req_valid = '0;
        check("clr_count", 32'(n_clear), 32'd32);
        for (int i = 0; i < 6; i++) step(0, '0);

        // clr_all twice during a write and once during the sweep: exactly one sweep
        n_clear = 0; n_done = 0;
        for (int i = 0; i < 45; i++) begin
            req_valid = (i == 0) ? 3'b001 : 3'b000;
            clr_all = (i == 1 || i == 3 || i == 15);
            step(0, '0);
            if (i == 6) check("sweep_start", 32'({last_act[19], last_act[18:14], last_act[11:10]}), 32'({1'b1, 5'd0, 2'b11}));
        end
        clr_all = 1'b0;
        check("merged_clears", 32'(n_clear), 32'd32);
        check("merged_dones", 32'(n_done), 32'd2);

        // reset on the field-1 load cycle
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            rst = (i == 2);
            req_valid = (i == 0) ? 3'b010 : (i == 4) ? 3'b111 : 3'b000;
            step(0, '0);
            if (i == 3) check("rst_abort", 32'({last_act[19], last_act[0]}), 32'd0);
            if (i == 4) check("rst_rr_grant", 32'(last_act[22:20]), 32'(3'b001));
        end
        check("rst_no_done", 32'(n_done), 32'd1);

        // randomized traffic with changing slot/data between accepts
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            req_valid = 3'($urandom);
            clr_all = ($urandom_range(0, 39) == 0);
            for (int k = 0; k < NREQ; k++) begin
                sl[k] = 5'($urandom);
                dt[k] = $urandom;
            end
            step(0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/telem_write_sequencer.md
# telem_write_sequencer

Sequences writes into the 32-slot telemetry coordinate bank: the slot decoder plus the per-bit hold/load/clear muxes in front of the coordinate DFFs. Arbitrates round-robin between several telemetry sources (GPS, IMU, host) that each submit a full record (x, y, z, time; 8 bits each) for one slot. Serialises each record into four per-field bank loads and also runs a whole-bank clear sweep. It is the only driver of the bank's decoder-enable, slot-address, field, mux-select and data lines.

## Interface
- NREQ, 3, number of requesters (2..8)
- W, 8, field width in bits
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; synchronous, active-high
- req_valid  in  NREQ  requester i has a record pending
- req_ready  out  NREQ  one-hot grant; record accepted when req_valid[i] & req_ready[i]
- req_slot  in  NREQ*5  target slot per requester, {slot[NREQ-1],…,slot[0]}
- req_data  in  NREQ*4*W  record per requester, {time,z,y,x}, x in LSBs
- clr_all  in  1  single-cycle request to clear all 32 slots
- bank_en  out  1  decoder enable; high only on active bank cycles
- bank_addr  out  5  slot driven to the decoder
- bank_field  out  2  0=x, 1=y, 2=z, 3=time
- bank_sel  out  2  mux select: 00 hold, 01 load, 11 clear
- bank_data  out  W  field value for load cycles
- busy  out  1  high in WRITE or CLEAR
- done  out  1  one-cycle pulse after a record or sweep completes

## Operation
- States: IDLE, WRITE, CLEAR.
- IDLE:
  - If clr_pend or clr_all is set, go to CLEAR. Clear has priority over requests, and req_ready stays 0.
  - Otherwise, if any req_valid is set, the round-robin winner gets a combinational req_ready in that cycle. Its slot and record are captured at the edge, and the state goes to WRITE.
- Round-robin: priority starts at rr_ptr. After granting i, rr_ptr = (i+1) mod NREQ. It is 0 after reset.
- WRITE, 4 cycles (field 0..3):
  - bank_en=1, bank_sel=01, bank_addr=captured slot, bank_data=captured field.
  - After field 3, return to IDLE and pulse done.
- CLEAR, 32 cycles (slot 0..31):
  - bank_en=1, bank_sel=11, bank_field=0, bank_data=0.
  - Each cycle clears all fields of bank_addr.
  - After slot 31, return to IDLE, pulse done, and clear clr_pend.
- clr_all in WRITE sets clr_pend. The sweep starts immediately after the record, with no request grant in between.
- clr_all in CLEAR, or while clr_pend is already set, is merged. It produces no extra sweep.
- All bank_* outputs are 0 in IDLE (bank_sel=00, hold).
- req_data and req_slot are ignored except in the accept cycle. A requester that drops req_valid before being granted loses nothing.

## Timing
- Reset values (the cycle after rst high):
  - state IDLE, rr_ptr 0, clr_pend 0.
  - req_ready 0, bank_en 0, bank_addr 0, bank_field 0, bank_sel 00, bank_data 0, busy 0, done 0.
- rst mid-WRITE or mid-CLEAR:
  - Outputs go to reset values at the next edge.
  - No done pulse. Pending clear is dropped. Partial bank writes are not undone.
- Record accepted at cycle t:
  - Bank load cycles are t+1..t+4, fields x,y,z,time.
  - done and IDLE are at t+5, and a new grant can occur at t+5.
  - Throughput: 1 record per 5 cycles.
- Sweep started at IDLE cycle t:
  - Clear cycles are t+1..t+32, addr 0..31.
  - done is at t+33.
- busy is registered and high exactly on bank_en cycles.
- All outputs are registered except req_ready.

## Structure
- Package telem_pkg:
  - SEL_HOLD=2'b00, SEL_LOAD=2'b01, SEL_CLEAR=2'b11
  - field codes FLD_X..FLD_TIME
  - NSLOT=32
  - the state encoding
- Sub-module telem_rr_arbiter:
  - inputs: NREQ valid vector, rr_ptr, enable
  - outputs: one-hot grant and grant index
  - purely combinational
- The top level holds the FSM, capture registers, the field/slot counter and clr_pend.

## Test plan
- Reset: hold rst 2 cycles with req_valid=3'b111 → req_ready=0 during reset. All outputs are at reset values. The first grant after release goes to requester 0.
- Single write: req_valid[1]=1, slot 7, data 32'h40302010 at t → req_ready=3'b010 at t. At t+1..t+4: addr 7, field 0..3, data 10/20/30/40, sel 01. done at t+5.
- Round-robin: all three valid continuously → grants 0,1,2,0 at t, t+5, t+10, t+15.
- clr_all and req_valid[2] together in IDLE at t → 32 clear cycles (addr 0..31, sel 11), done at t+33. Requester 2 is granted at t+33.
- clr_all pulsed twice during a WRITE, once more during the sweep → record completes, then exactly one sweep starts immediately, then IDLE.
- rst at the 2nd load cycle of a write (field 1) → bank_en=0 the next cycle, no done. A subsequent grant starts from requester 0.
